// File: rtl/register_file_bank_pkg.sv
// register_file_bank_pkg: shared helpers for the register file bank.
//   addr_in_range(addr, num) - 1 when addr indexes one of num registers.
package register_file_bank_pkg;

   function automatic logic addr_in_range(input int unsigned addr, input int unsigned num);
      return addr < num;
   endfunction

endpackage

// File: rtl/register_file_bank.sv
// register_file_bank: flop-based register file with one write and one read port.
//   clk_i / rst_ni        clock, synchronous active-low reset (registers -> all-ones)
//   write_valid_i/_ready_o, write_addr_i, write_data_i   write request (never stalls)
//   read_valid_i/_ready_o, read_addr_i                   read request
//   read_valid_o, read_addr_o, read_data_o               read response, 1-cycle latency
// DualPort=0 shares one port: a write blocks a read in the same cycle.
// Define REGISTER_FILE_BANK_ASSERT_EN to compile in simulation assertions.
module register_file_bank
   import register_file_bank_pkg::*;
#(
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned NumRegisters = 256,
   parameter bit          DualPort     = 1'b0,
   localparam int unsigned AddrWidth   = $clog2(NumRegisters)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 write_valid_i,
   output logic                 write_ready_o,
   input  logic [AddrWidth-1:0] write_addr_i,
   input  logic [DataWidth-1:0] write_data_i,
   input  logic                 read_valid_i,
   output logic                 read_ready_o,
   input  logic [AddrWidth-1:0] read_addr_i,
   output logic                 read_valid_o,
   output logic [AddrWidth-1:0] read_addr_o,
   output logic [DataWidth-1:0] read_data_o
);

   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [DataWidth-1:0] data_t;

   data_t mem_q [NumRegisters];
   logic  read_valid_q, read_valid_d;
   addr_t read_addr_q, read_addr_d;
   data_t read_data_q, read_data_d;
   logic  wr_hs, rd_hs, wr_ok, rd_ok;

   assign write_ready_o = 1'b1;
   assign read_ready_o  = DualPort ? 1'b1 : !write_valid_i;
   assign wr_hs         = write_valid_i & write_ready_o;
   assign rd_hs         = read_valid_i & read_ready_o;
   // only matters when NumRegisters is not a power of two
   assign wr_ok         = addr_in_range(32'(write_addr_i), NumRegisters);
   assign rd_ok         = addr_in_range(32'(read_addr_i), NumRegisters);

   // read samples the array before this edge's write lands: read-before-write
   always_comb begin
      read_valid_d = rd_hs;
      read_addr_d  = rd_hs ? read_addr_i : read_addr_q;
      read_data_d  = rd_hs ? (rd_ok ? mem_q[read_addr_i] : '1) : read_data_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NumRegisters; i++) mem_q[i] <= '1;
      end else if (wr_hs && wr_ok) begin
         mem_q[write_addr_i] <= write_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         read_valid_q <= 1'b0;
         read_addr_q  <= '0;
         read_data_q  <= '0;
      end else begin
         read_valid_q <= read_valid_d;
         read_addr_q  <= read_addr_d;
         read_data_q  <= read_data_d;
      end
   end

   assign read_valid_o = read_valid_q;
   assign read_addr_o  = read_addr_q;
   assign read_data_o  = read_data_q;

`ifdef REGISTER_FILE_BANK_ASSERT_EN
   a_write_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
      write_valid_i |-> write_ready_o);
   a_valid_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown(read_valid_i) && !$isunknown(write_valid_i));
   if (!DualPort) begin : g_sp_assert
      a_write_blocks_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
         write_valid_i |-> !read_ready_o);
   end
`else
   // assertions compiled out; behaviour is unchanged
`endif

endmodule

// File: tb/tb_register_file_bank.sv
// tb_register_file_bank: directed vector bench for single-port and dual-port builds.
module tb_register_file_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wv, rv;
   logic [7:0]  wa, ra;
   logic [31:0] wd;
   logic        s_wrdy, s_rrdy, s_v, d_wrdy, d_rrdy, d_v;
   logic [7:0]  s_a, d_a;
   logic [31:0] s_d, d_d;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   register_file_bank u_sp (
      .clk_i(clk), .rst_ni(rst_n),
      .write_valid_i(wv), .write_ready_o(s_wrdy), .write_addr_i(wa), .write_data_i(wd),
      .read_valid_i(rv), .read_ready_o(s_rrdy), .read_addr_i(ra),
      .read_valid_o(s_v), .read_addr_o(s_a), .read_data_o(s_d)
   );

   register_file_bank #(.DataWidth(32), .NumRegisters(200), .DualPort(1'b1)) u_dp (
      .clk_i(clk), .rst_ni(rst_n),
      .write_valid_i(wv), .write_ready_o(d_wrdy), .write_addr_i(wa), .write_data_i(wd),
      .read_valid_i(rv), .read_ready_o(d_rrdy), .read_addr_i(ra),
      .read_valid_o(d_v), .read_addr_o(d_a), .read_data_o(d_d)
   );

   typedef struct {
      logic        wv;
      logic [7:0]  wa;
      logic [31:0] wd;
      logic        rv;
      logic [7:0]  ra;
      logic        s_rdy;
      logic        s_v;
      logic [7:0]  s_a;
      logic [31:0] s_d;
      logic        d_v;
      logic [7:0]  d_a;
      logic [31:0] d_d;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic w, input logic [7:0] a_w, input logic [31:0] d_w,
                        input logic r, input logic [7:0] a_r);
      @(negedge clk);
      wv = w; wa = a_w; wd = d_w; rv = r; ra = a_r;
   endtask

   task automatic chk_resp(input string tag, input logic sv, input logic [7:0] sa, input logic [31:0] sd,
                           input logic dv, input logic [7:0] da, input logic [31:0] dd);
      chk({tag, " sp_valid"}, 32'(s_v), 32'(sv));
      chk({tag, " sp_addr"}, 32'(s_a), 32'(sa));
      chk({tag, " sp_data"}, s_d, sd);
      chk({tag, " dp_valid"}, 32'(d_v), 32'(dv));
      chk({tag, " dp_addr"}, 32'(d_a), 32'(da));
      chk({tag, " dp_data"}, d_d, dd);
   endtask

   initial begin
      // inputs, sp ready, sp response, dp response
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 32'hFFFFFFFF, 1'b1, 8'h05, 32'hFFFFFFFF});
      vq.push_back('{1'b1, 8'h10, 32'h00ABCDEF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 32'hFFFFFFFF, 1'b0, 8'h05, 32'hFFFFFFFF});
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 32'h00ABCDEF, 1'b1, 8'h10, 32'h00ABCDEF});
      vq.push_back('{1'b1, 8'h20, 32'h00000001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 32'h00ABCDEF, 1'b0, 8'h10, 32'h00ABCDEF});
      vq.push_back('{1'b1, 8'h20, 32'h00123456, 1'b1, 8'h20, 1'b0, 1'b0, 8'h10, 32'h00ABCDEF, 1'b1, 8'h20, 32'h00000001});
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 8'h20, 1'b1, 1'b1, 8'h20, 32'h00123456, 1'b1, 8'h20, 32'h00123456});
      vq.push_back('{1'b1, 8'h30, 32'hCAFEF00D, 1'b1, 8'h10, 1'b0, 1'b0, 8'h20, 32'h00123456, 1'b1, 8'h10, 32'h00ABCDEF});
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 8'h30, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 1'b1, 8'h30, 32'hCAFEF00D});
      vq.push_back('{1'b1, 8'hC8, 32'h55AA55AA, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 32'hCAFEF00D, 1'b0, 8'h30, 32'hCAFEF00D});
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 8'hC8, 1'b1, 1'b1, 8'hC8, 32'h55AA55AA, 1'b1, 8'hC8, 32'hFFFFFFFF});
      vq.push_back('{1'b1, 8'hC7, 32'h0BADBEEF, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC8, 32'h55AA55AA, 1'b0, 8'hC8, 32'hFFFFFFFF});
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 8'hC7, 1'b1, 1'b1, 8'hC7, 32'h0BADBEEF, 1'b1, 8'hC7, 32'h0BADBEEF});
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 32'hFFFFFFFF, 1'b1, 8'hFF, 32'hFFFFFFFF});
      vq.push_back('{1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 32'hFFFFFFFF, 1'b0, 8'hFF, 32'hFFFFFFFF});

      // reset with handshakes present: they must be ignored
      rst_n = 1'b0; wv = 1'b1; wa = 8'h10; wd = 32'h0; rv = 1'b1; ra = 8'h05;
      repeat (3) @(posedge clk);
      #1 chk_resp("reset", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0);
      chk("reset sp_wready", 32'(s_wrdy), 32'd1);
      chk("reset dp_wready", 32'(d_wrdy), 32'd1);
      drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_resp("post_reset", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0);

      foreach (vq[i]) begin
         drive(vq[i].wv, vq[i].wa, vq[i].wd, vq[i].rv, vq[i].ra);
         #1;
         chk($sformatf("v%0d sp_rready", i), 32'(s_rrdy), 32'(vq[i].s_rdy));
         chk($sformatf("v%0d dp_rready", i), 32'(d_rrdy), 32'd1);
         chk($sformatf("v%0d sp_wready", i), 32'(s_wrdy), 32'd1);
         @(posedge clk);
         #1 chk_resp($sformatf("v%0d", i), vq[i].s_v, vq[i].s_a, vq[i].s_d, vq[i].d_v, vq[i].d_a, vq[i].d_d);
      end

      // read handshake, then reset the following cycle drops the response
      drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h10);
      @(posedge clk);
      #1 chk_resp("pre_rst_read", 1'b1, 8'h10, 32'h00ABCDEF, 1'b1, 8'h10, 32'h00ABCDEF);
      drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h30);
      rst_n = 1'b0;
      @(posedge clk);
      #1 chk_resp("rst_drop", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0);
      drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_resp("rst_idle", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0);
      drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h10);
      @(posedge clk);
      #1 chk_resp("rst_mem10", 1'b1, 8'h10, 32'hFFFFFFFF, 1'b1, 8'h10, 32'hFFFFFFFF);
      drive(1'b0, 8'h00, 32'h0, 1'b1, 8'hC7);
      @(posedge clk);
      #1 chk_resp("rst_memC7", 1'b1, 8'hC7, 32'hFFFFFFFF, 1'b1, 8'hC7, 32'hFFFFFFFF);
      drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
      @(posedge clk);
      #1 chk_resp("final_idle", 1'b0, 8'hC7, 32'hFFFFFFFF, 1'b0, 8'hC7, 32'hFFFFFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
